// File: rtl/aes_block_loader.sv
// Byte-serial plaintext loader: assembles NBYTES bytes into one block, checks
// last-byte framing, and hands the block off over a valid/ready port.
module aes_block_loader #(
    parameter int NBYTES = 16,
    parameter int CW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_block,
    output logic                frame_err,
    output logic [CW-1:0]       blk_count
);

    localparam int BW   = 8 * NBYTES;
    localparam int CNTW = $clog2(NBYTES);

    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBYTES - 1);
    localparam logic [CW-1:0]   BLK_ONE  = CW'(1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic            err_q, err_d;
    logic [CW-1:0]   blk_q, blk_d;

    logic accept;
    logic last_slot;

    // Handshake strobes decode purely from the state register, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_block = buf_q;
    assign frame_err = err_q;
    assign blk_count = blk_q;

    assign accept    = in_valid & in_ready;
    assign last_slot = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default hold value first, so no
        // path through the case statement leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        blk_d   = blk_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d = {buf_q[BW-9:0], in_data};
                    if (in_last && last_slot) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else if (in_last || last_slot) begin
                        // Early or missing last: drop the frame and restart.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = FILL;
                    blk_d   = blk_q + BLK_ONE;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            blk_q   <= blk_d;
        end
    end

endmodule
